// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - per-FU completion queues with round-robin CDB arbitration and squash filtering
module cdb_arbiter #(
  parameter int NUM_FU      = 4,
  parameter int QDEPTH      = 2,
  parameter int XLEN        = 32,
  parameter int TAG_W       = 4,
  parameter int ROB_ENTRIES = 9
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_FU-1:0]         fu_valid,
  input  logic [NUM_FU*TAG_W-1:0]   fu_tag,
  input  logic [NUM_FU*XLEN-1:0]    fu_value,
  output logic [NUM_FU-1:0]         fu_ready,
  input  logic [TAG_W-1:0]          rob_head_tag,
  input  logic                      squash_valid,
  input  logic [TAG_W-1:0]          squash_tag,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [XLEN-1:0]           cdb_value
);

  localparam int PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int AW = TAG_W + 2;
  localparam logic [CW-1:0] QD_C  = CW'(QDEPTH);
  localparam logic [AW-1:0] ROB_C = AW'(ROB_ENTRIES);
  localparam logic [PW:0]   NFU_C = (PW + 1)'(NUM_FU);

  // Queue storage: slot 0 is always the head, survivors are kept packed toward it.
  logic [TAG_W-1:0] q_tag [NUM_FU][QDEPTH];
  logic [XLEN-1:0]  q_val [NUM_FU][QDEPTH];
  logic [CW-1:0]    q_cnt [NUM_FU];
  logic [PW-1:0]    rr_ptr;

  logic [TAG_W-1:0] n_tag [NUM_FU][QDEPTH];
  logic [XLEN-1:0]  n_val [NUM_FU][QDEPTH];
  logic [CW-1:0]    n_cnt [NUM_FU];
  logic [PW-1:0]    n_rr;
  logic             n_cdb_valid;
  logic [TAG_W-1:0] n_cdb_tag;
  logic [XLEN-1:0]  n_cdb_value;

  logic             win_found;
  logic [PW-1:0]    win_idx;
  logic [PW:0]      scan;
  logic [CW-1:0]    fill;
  logic             keep;
  logic             push;
  logic [AW-1:0]    squash_age;

  // Distance of a tag from the ROB head, modulo the ROB size (tags are 1-based).
  function automatic logic [AW-1:0] age(input logic [TAG_W-1:0] t, input logic [TAG_W-1:0] h);
    logic [AW-1:0] d;
    d = AW'(t) + ROB_C - AW'(h);
    if (d >= ROB_C) d = d - ROB_C;
    return d;
  endfunction

  function automatic logic younger(input logic [TAG_W-1:0] t, input logic sq,
                                   input logic [AW-1:0] sa, input logic [TAG_W-1:0] h);
    return sq && (age(t, h) > sa);
  endfunction

  assign squash_age = age(squash_tag, rob_head_tag);

  // Space flag comes straight from the registered count, independent of this cycle's grant.
  always_comb begin
    fu_ready = '0;
    for (int i = 0; i < NUM_FU; i++) fu_ready[i] = (q_cnt[i] < QD_C);
  end

  // Pick a winner, then rebuild every queue: drop popped/squashed entries, compact, append.
  always_comb begin
    win_found   = 1'b0;
    win_idx     = '0;
    scan        = '0;
    fill        = '0;
    keep        = 1'b0;
    push        = 1'b0;
    n_tag       = q_tag;
    n_val       = q_val;
    n_cnt       = q_cnt;
    n_rr        = rr_ptr;
    n_cdb_valid = 1'b0;
    n_cdb_tag   = '0;
    n_cdb_value = '0;

    for (int k = 0; k < NUM_FU; k++) begin
      scan = {1'b0, rr_ptr} + (PW + 1)'(k);
      if (scan >= NFU_C) scan = scan - NFU_C;
      if (!win_found && (q_cnt[scan[PW-1:0]] != '0) &&
          !younger(q_tag[scan[PW-1:0]][0], squash_valid, squash_age, rob_head_tag)) begin
        win_found = 1'b1;
        win_idx   = scan[PW-1:0];
      end
    end

    if (win_found) begin
      n_cdb_valid = 1'b1;
      n_cdb_tag   = q_tag[win_idx][0];
      n_cdb_value = q_val[win_idx][0];
      scan = {1'b0, win_idx} + (PW + 1)'(1);
      if (scan >= NFU_C) scan = scan - NFU_C;
      n_rr = scan[PW-1:0];
    end

    for (int i = 0; i < NUM_FU; i++) begin
      fill = '0;
      for (int j = 0; j < QDEPTH; j++) begin
        keep = (CW'(j) < q_cnt[i]) &&
               !younger(q_tag[i][j], squash_valid, squash_age, rob_head_tag) &&
               !(win_found && (win_idx == PW'(i)) && (j == 0));
        if (keep) begin
          for (int d = 0; d < QDEPTH; d++) begin
            if (CW'(d) == fill) begin
              n_tag[i][d] = q_tag[i][j];
              n_val[i][d] = q_val[i][j];
            end
          end
          fill = fill + CW'(1);
        end
      end
      push = fu_valid[i] && fu_ready[i] && (fu_tag[i*TAG_W +: TAG_W] != '0) &&
             !younger(fu_tag[i*TAG_W +: TAG_W], squash_valid, squash_age, rob_head_tag);
      if (push) begin
        for (int d = 0; d < QDEPTH; d++) begin
          if (CW'(d) == fill) begin
            n_tag[i][d] = fu_tag[i*TAG_W +: TAG_W];
            n_val[i][d] = fu_value[i*XLEN +: XLEN];
          end
        end
        fill = fill + CW'(1);
      end
      n_cnt[i] = fill;
    end
  end

  // Control state and CDB output register; reset empties every queue.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_FU; i++) q_cnt[i] <= '0;
      rr_ptr    <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_value <= '0;
    end else begin
      q_cnt     <= n_cnt;
      rr_ptr    <= n_rr;
      cdb_valid <= n_cdb_valid;
      cdb_tag   <= n_cdb_tag;
      cdb_value <= n_cdb_value;
    end
  end

  // Payload slots need no reset; the counts decide what is live.
  always_ff @(posedge clock) begin
    q_tag <= n_tag;
    q_val <= n_val;
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - scoreboard bench for cdb_arbiter with a queue-based reference model
module tb_cdb_arbiter;

  localparam int NF = 4;
  localparam int QD = 2;
  localparam int XL = 32;
  localparam int TW = 4;
  localparam int RE = 9;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                reset;
  logic [NF-1:0]       fu_valid;
  logic [NF*TW-1:0]    fu_tag;
  logic [NF*XL-1:0]    fu_value;
  logic [NF-1:0]       fu_ready;
  logic [TW-1:0]       rob_head_tag;
  logic                squash_valid;
  logic [TW-1:0]       squash_tag;
  logic                cdb_valid;
  logic [TW-1:0]       cdb_tag;
  logic [XL-1:0]       cdb_value;

  cdb_arbiter #(.NUM_FU(NF), .QDEPTH(QD), .XLEN(XL), .TAG_W(TW), .ROB_ENTRIES(RE)) dut (
    .clock(clock), .reset(reset), .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_value(fu_value),
    .fu_ready(fu_ready), .rob_head_tag(rob_head_tag), .squash_valid(squash_valid),
    .squash_tag(squash_tag), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value)
  );

  typedef struct { int tag; logic [31:0] val; } ent_t;
  typedef struct { logic v; logic [3:0] tag; logic [31:0] val; logic [3:0] rdy; } exp_t;

  int checks = 0;
  int failures = 0;

  logic [NF-1:0] s_valid;
  int            s_tag [NF];
  logic [31:0]   s_val [NF];
  int            s_head;
  logic          s_sq;
  int            s_sqtag;
  logic          s_rst;

  ent_t mq [NF][$];
  int   rr;
  exp_t sb [$];
  int   log_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int age(input int t, input int h);
    return ((t - h) % RE + RE) % RE;
  endfunction

  function automatic bit younger(input int t);
    return s_sq && (age(t, s_head) > age(s_sqtag, s_head));
  endfunction

  // Reference: plain queues, a round-robin pointer and the age rule.
  task automatic model_step();
    exp_t e;
    int   win;
    bit   rdy [NF];
    ent_t tmp [$];
    ent_t ne;
    e.v = 1'b0; e.tag = '0; e.val = '0; e.rdy = '0;
    win = -1;
    if (s_rst) begin
      for (int i = 0; i < NF; i++) mq[i].delete();
      rr = 0;
    end else begin
      for (int i = 0; i < NF; i++) rdy[i] = (mq[i].size() < QD);
      for (int k = 0; k < NF; k++) begin
        int idx;
        idx = (rr + k) % NF;
        if (win < 0 && mq[idx].size() > 0 && !younger(mq[idx][0].tag)) win = idx;
      end
      if (win >= 0) begin
        e.v   = 1'b1;
        e.tag = 4'(mq[win][0].tag);
        e.val = mq[win][0].val;
        void'(mq[win].pop_front());
        rr = (win + 1) % NF;
      end
      if (s_sq) begin
        for (int i = 0; i < NF; i++) begin
          tmp.delete();
          for (int j = 0; j < mq[i].size(); j++)
            if (!younger(mq[i][j].tag)) tmp.push_back(mq[i][j]);
          mq[i] = tmp;
        end
      end
      for (int i = 0; i < NF; i++) begin
        if (s_valid[i] && rdy[i] && s_tag[i] != 0 && !younger(s_tag[i])) begin
          ne.tag = s_tag[i];
          ne.val = s_val[i];
          mq[i].push_back(ne);
        end
      end
    end
    for (int i = 0; i < NF; i++) e.rdy[i] = (mq[i].size() < QD);
    sb.push_back(e);
  endtask

  task automatic tick();
    @(negedge clock);
    reset        = s_rst;
    fu_valid     = s_valid;
    for (int i = 0; i < NF; i++) begin
      fu_tag[i*TW +: TW]   = TW'(s_tag[i]);
      fu_value[i*XL +: XL] = s_val[i];
    end
    rob_head_tag = TW'(s_head);
    squash_valid = s_sq;
    squash_tag   = TW'(s_sqtag);
    model_step();
  endtask

  task automatic idle();
    s_valid = '0; s_sq = 1'b0; s_rst = 1'b0; s_sqtag = 1;
    for (int i = 0; i < NF; i++) begin s_tag[i] = 0; s_val[i] = '0; end
  endtask

  task automatic do_reset(input int head);
    idle(); s_head = head; s_rst = 1'b1; tick(); idle();
    log_q.delete();
  endtask

  task automatic check_log(input string name, input int n, input int e0 = 0, input int e1 = 0,
                           input int e2 = 0, input int e3 = 0, input int e4 = 0);
    int e [5];
    e = '{e0, e1, e2, e3, e4};
    chk({name, "_count"}, 32'(log_q.size()), 32'(n));
    for (int k = 0; k < n; k++)
      chk({name, "_order"}, (k < log_q.size()) ? 32'(log_q[k]) : 32'hFFFF_FFFF, 32'(e[k]));
  endtask

  // Monitor: every cycle the DUT presents one output word, matched against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("cdb_valid", 32'(cdb_valid), 32'(e.v));
        chk("cdb_tag",   32'(cdb_tag),   32'(e.tag));
        chk("cdb_value", cdb_value,      e.val);
        chk("fu_ready",  32'(fu_ready),  32'(e.rdy));
        if (cdb_valid === 1'b1) log_q.push_back(int'(cdb_tag));
      end
    end
  end

  initial begin
    reset = 1'b1; fu_valid = '0; fu_tag = '0; fu_value = '0;
    rob_head_tag = 4'd1; squash_valid = 1'b0; squash_tag = 4'd1;
    rr = 0;

    // Single result
    do_reset(1);
    s_valid = 4'b0010; s_tag[1] = 3; s_val[1] = 32'hDEAD; tick(); idle();
    repeat (4) tick();
    check_log("single", 1, 3);

    // Contention from rr_ptr=0
    do_reset(1);
    s_valid = 4'b1111; for (int i = 0; i < NF; i++) begin s_tag[i] = i + 1; s_val[i] = 32'h100 + i; end
    tick(); idle();
    repeat (6) tick();
    check_log("contention", 4, 1, 2, 3, 4);

    // Full queue on FU2
    do_reset(1);
    s_valid = 4'b1111; s_tag = '{1, 2, 5, 3}; tick(); idle();
    s_valid = 4'b0100; s_tag[2] = 6; tick(); idle();
    s_valid = 4'b0100; s_tag[2] = 7; tick();
    chk("full_ready2", 32'(fu_ready[2]), 32'd0);
    idle();
    repeat (7) tick();
    check_log("full", 5, 1, 2, 5, 3, 6);

    // Squash, plain ordering
    do_reset(1);
    s_valid = 4'b0111; s_tag = '{2, 4, 7, 0}; tick(); idle();
    s_sq = 1'b1; s_sqtag = 4; tick(); idle();
    repeat (5) tick();
    check_log("squash", 2, 2, 4);

    // Squash, tag wrap
    do_reset(8);
    s_valid = 4'b0011; s_tag = '{9, 2, 0, 0}; tick(); idle();
    s_sq = 1'b1; s_sqtag = 1; tick(); idle();
    repeat (5) tick();
    check_log("squash_wrap", 1, 9);

    // Reset mid-flight
    do_reset(1);
    s_valid = 4'b0111; s_tag = '{1, 2, 3, 0}; tick(); idle();
    s_rst = 1'b1; tick(); idle();
    tick();
    chk("midrst_ready", 32'(fu_ready), 32'hF);
    repeat (4) tick();
    chk("midrst_silent", 32'(log_q.size()), 32'd0);

    // Tag zero
    do_reset(1);
    s_valid = 4'b0001; s_tag[0] = 0; s_val[0] = 32'h55; tick(); idle();
    tick();
    chk("tag0_ready", 32'(fu_ready), 32'hF);
    repeat (3) tick();
    chk("tag0_silent", 32'(log_q.size()), 32'd0);

    // Randomized traffic
    do_reset(1);
    for (int c = 0; c < 800; c++) begin
      s_rst   = ($urandom_range(0, 63) == 0);
      s_valid = 4'($urandom);
      for (int i = 0; i < NF; i++) begin
        s_tag[i] = $urandom_range(0, RE);
        s_val[i] = $urandom;
      end
      if ($urandom_range(0, 3) == 0) s_head = $urandom_range(1, RE);
      s_sq    = ($urandom_range(0, 7) == 0);
      s_sqtag = $urandom_range(1, RE);
      tick();
    end
    idle();
    repeat (12) tick();

    repeat (2) @(posedge clock);
    #2;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
